// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage memory controller.
// Contents: the UART register map, the FSM state encoding and the ram1 read/write polarity.
package mem_pkg;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  // ram1 'read' input polarity: 0 requests a read, 1 requests a write.
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SRAM  = 3'd1,
    U_RD1 = 3'd2,
    U_RD2 = 3'd3,
    U_WR1 = 3'd4,
    U_WR2 = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// MEM-stage sequencing controller: accepts one load/store per handshake and drives ram1 or the board UART.
// Every strobe and bus output is registered from the next state, so the outputs change on the same edge as the state.
module mem_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = mem_pkg::UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT_ADDR = mem_pkg::UART_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_data,
  output logic        ram_read,
  input  logic [15:0] ram_rdata,
  output logic        ram_en_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);
  import mem_pkg::*;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_we;
  logic        r_we;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [15:0] r_resp_data;
  logic [17:0] r_ram_addr;
  logic [15:0] r_ram_data;
  logic        r_ram_read;
  logic        r_ram_en_n;
  logic        r_uart_rdn;
  logic        r_uart_wrn;

  function automatic state_t decode(input logic [15:0] addr, input logic we);
    if (addr == UART_DATA_ADDR) return we ? U_WR1 : U_RD1;
    if (addr == UART_STAT_ADDR) return DONE;
    return SRAM;
  endfunction

  assign w_accept = (r_state == IDLE) && req_valid;
  // While a request is being accepted, the latched direction is not yet in r_we.
  assign w_we     = w_accept ? req_we : r_we;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = decode(req_addr, req_we);
      SRAM:    w_next = DONE;
      U_RD1:   w_next = U_RD2;
      U_RD2:   w_next = DONE;
      U_WR1:   w_next = U_WR2;
      U_WR2:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 16'h0000;
      r_ram_addr   <= 18'h00000;
      r_ram_data   <= 16'h0000;
      r_ram_read   <= READ;
      r_ram_en_n   <= 1'b1;
      r_uart_rdn   <= 1'b1;
      r_uart_wrn   <= 1'b1;
    end else begin
      r_state      <= w_next;
      r_req_ready  <= (w_next == IDLE);
      r_resp_valid <= (w_next == DONE);
      r_ram_en_n   <= (w_next != SRAM);
      r_uart_rdn   <= !((w_next == U_RD1) || (w_next == U_RD2));
      r_uart_wrn   <= (w_next != U_WR1);
      case (w_next)
        SRAM:         r_ram_read <= w_we;
        U_WR1, U_WR2: r_ram_read <= WRITE;
        default:      r_ram_read <= READ;
      endcase

      if (w_accept) begin
        r_we       <= req_we;
        r_ram_addr <= {2'b00, req_addr};
        r_ram_data <= req_wdata;
      end

      // Load results only; stores and status writes leave the previous value in place.
      if (w_accept && !req_we && (req_addr == UART_STAT_ADDR))
        r_resp_data <= {14'b0, data_ready, tbre & tsre};
      else if ((r_state == SRAM) && (r_we == READ))
        r_resp_data <= ram_rdata;
      else if (r_state == U_RD2)
        r_resp_data <= {8'b0, ram_rdata[7:0]};
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign ram_read   = r_ram_read;
  assign ram_en_n   = r_ram_en_n;
  assign uart_rdn   = r_uart_rdn;
  assign uart_wrn   = r_uart_wrn;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl, with a ram1/SRAM model and a UART read-data model attached.
// Expected results come from an address-class reference model that keeps memory contents in an associative array.
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [15:0] resp_data;
   logic [17:0] ram_addr;
   logic [15:0] ram_data;
   logic        ram_read;
   logic [15:0] ram_rdata;
   logic        ram_en_n;
   logic        uart_rdn;
   logic        uart_wrn;
   logic        data_ready;
   logic        tbre;
   logic        tsre;

   logic [15:0] uartVal;
   logic [15:0] sramQ;
   logic [15:0] sramMem [0:262143];
   logic [15:0] refMem [int];

   int totalChecks = 0;
   int badChecks = 0;

   mem_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_read(ram_read), .ram_rdata(ram_rdata),
      .ram_en_n(ram_en_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
      .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ram1 behaviour: the SRAM is accessed on the falling edge while the chip enable is low.
   always @(negedge clk) begin
      if (!ram_en_n) begin
         if (ram_read) sramMem[ram_addr] = ram_data;
         else sramQ = sramMem[ram_addr];
      end
   end

   // The UART shares the data bus with the SRAM and drives it while its read strobe is low.
   assign ram_rdata = (!uart_rdn) ? uartVal : sramQ;

   function automatic logic [15:0] refRead(input logic [15:0] a);
      return refMem.exists(int'(a)) ? refMem[int'(a)] : 16'h0000;
   endfunction

   // Drives one request at a falling edge and observes the access cycle by cycle until resp_valid appears.
   task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                output int lat, output logic [15:0] data, output int enLow,
                                output int rdnLow, output int wrnLow, output int readHigh,
                                output int readyLow, output logic [15:0] busData,
                                output logic [17:0] busAddr, output logic readyAtStart);
      @(negedge clk);
      readyAtStart = req_ready;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      lat = 0; data = 16'h0000; enLow = 0; rdnLow = 0; wrnLow = 0; readHigh = 0; readyLow = 0;
      busData = 16'h0000; busAddr = 18'h0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (!ram_en_n) enLow++;
         if (!uart_rdn) rdnLow++;
         if (!uart_wrn) wrnLow++;
         if (ram_read) readHigh++;
         if (!req_ready) readyLow++;
         if (!ram_en_n || !uart_wrn) begin busData = ram_data; busAddr = ram_addr; end
         if (resp_valid) begin lat = k; data = resp_data; break; end
      end
   endtask

   task automatic test_reset();
      #12;
      totalChecks++; if (req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
      totalChecks++; if (resp_valid !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      totalChecks++; if (resp_data !== 16'h0) begin badChecks++; $display("[TB] FAIL reset_resp_data got=%h exp=0000", resp_data); end
      totalChecks++; if (ram_addr !== 18'h0) begin badChecks++; $display("[TB] FAIL reset_ram_addr got=%h exp=0", ram_addr); end
      totalChecks++; if (ram_data !== 16'h0) begin badChecks++; $display("[TB] FAIL reset_ram_data got=%h exp=0", ram_data); end
      totalChecks++; if (ram_read !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_ram_read got=%b exp=0", ram_read); end
      totalChecks++; if (ram_en_n !== 1'b1) begin badChecks++; $display("[TB] FAIL reset_ram_en_n got=%b exp=1", ram_en_n); end
      totalChecks++; if (uart_rdn !== 1'b1) begin badChecks++; $display("[TB] FAIL reset_uart_rdn got=%b exp=1", uart_rdn); end
      totalChecks++; if (uart_wrn !== 1'b1) begin badChecks++; $display("[TB] FAIL reset_uart_wrn got=%b exp=1", uart_wrn); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sram();
      int lat, enLow, rdnLow, wrnLow, readHigh, readyLow;
      logic [15:0] data, busData;
      logic [17:0] busAddr;
      logic rdy;
      applyStimulus(1'b1, 16'h0040, 16'h1234, lat, data, enLow, rdnLow, wrnLow, readHigh, readyLow, busData, busAddr, rdy);
      refMem[16'h0040] = 16'h1234;
      totalChecks++; if (lat !== 2) begin badChecks++; $display("[TB] FAIL sram_store_latency got=%0d exp=2", lat); end
      totalChecks++; if (readHigh !== 1) begin badChecks++; $display("[TB] FAIL sram_store_read_high got=%0d exp=1", readHigh); end
      totalChecks++; if (readyLow !== 2) begin badChecks++; $display("[TB] FAIL sram_store_ready_low got=%0d exp=2", readyLow); end
      totalChecks++; if (busData !== 16'h1234 || busAddr !== 18'h00040) begin badChecks++; $display("[TB] FAIL sram_store_bus got=%h@%h exp=1234@00040", busData, busAddr); end
      applyStimulus(1'b0, 16'h0040, 16'h0000, lat, data, enLow, rdnLow, wrnLow, readHigh, readyLow, busData, busAddr, rdy);
      totalChecks++; if (lat !== 2) begin badChecks++; $display("[TB] FAIL sram_load_latency got=%0d exp=2", lat); end
      totalChecks++; if (data !== refRead(16'h0040)) begin badChecks++; $display("[TB] FAIL sram_load_data got=%h exp=%h", data, refRead(16'h0040)); end
      totalChecks++; if (readyLow !== 2 || readHigh !== 0 || enLow !== 1) begin badChecks++; $display("[TB] FAIL sram_load_strobes ready_low=%0d read_high=%0d en_low=%0d exp=2/0/1", readyLow, readHigh, enLow); end
   endtask

   task automatic test_uart_status();
      int lat, enLow, rdnLow, wrnLow, readHigh, readyLow;
      logic [15:0] data, busData;
      logic [17:0] busAddr;
      logic rdy;
      data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
      applyStimulus(1'b0, 16'hBF01, 16'h0000, lat, data, enLow, rdnLow, wrnLow, readHigh, readyLow, busData, busAddr, rdy);
      totalChecks++; if (lat !== 1) begin badChecks++; $display("[TB] FAIL status_latency got=%0d exp=1", lat); end
      totalChecks++; if (data !== 16'h0002) begin badChecks++; $display("[TB] FAIL status_data got=%h exp=0002", data); end
      totalChecks++; if (enLow + rdnLow + wrnLow + readHigh !== 0) begin badChecks++; $display("[TB] FAIL status_strobes got=%0d exp=0", enLow + rdnLow + wrnLow + readHigh); end
   endtask

   task automatic test_uart_write();
      int lat, enLow, rdnLow, wrnLow, readHigh, readyLow;
      logic [15:0] data, busData;
      logic [17:0] busAddr;
      logic rdy;
      applyStimulus(1'b1, 16'hBF00, 16'h0041, lat, data, enLow, rdnLow, wrnLow, readHigh, readyLow, busData, busAddr, rdy);
      totalChecks++; if (wrnLow !== 1) begin badChecks++; $display("[TB] FAIL uart_wr_strobe got=%0d exp=1", wrnLow); end
      totalChecks++; if (enLow !== 0) begin badChecks++; $display("[TB] FAIL uart_wr_en_low got=%0d exp=0", enLow); end
      totalChecks++; if (busData !== 16'h0041) begin badChecks++; $display("[TB] FAIL uart_wr_data got=%h exp=0041", busData); end
      totalChecks++; if (lat !== 3) begin badChecks++; $display("[TB] FAIL uart_wr_latency got=%0d exp=3", lat); end
      totalChecks++; if (readHigh !== 2) begin badChecks++; $display("[TB] FAIL uart_wr_read_high got=%0d exp=2", readHigh); end
   endtask

   task automatic test_uart_read();
      int lat, enLow, rdnLow, wrnLow, readHigh, readyLow;
      logic [15:0] data, busData;
      logic [17:0] busAddr;
      logic rdy;
      uartVal = 16'hA55A;
      applyStimulus(1'b0, 16'hBF00, 16'h0000, lat, data, enLow, rdnLow, wrnLow, readHigh, readyLow, busData, busAddr, rdy);
      totalChecks++; if (rdnLow !== 2) begin badChecks++; $display("[TB] FAIL uart_rd_strobe got=%0d exp=2", rdnLow); end
      totalChecks++; if (data !== 16'h005A) begin badChecks++; $display("[TB] FAIL uart_rd_data got=%h exp=005a", data); end
      totalChecks++; if (lat !== 3 || enLow !== 0) begin badChecks++; $display("[TB] FAIL uart_rd_timing lat=%0d en_low=%0d exp=3/0", lat, enLow); end
   endtask

   task automatic test_busy();
      logic [15:0] junkAddr;
      logic [17:0] addrSeen;
      logic readSeen, respSeen;
      logic [15:0] dataSeen;
      int lat, enLow, rdnLow, wrnLow, readHigh, readyLow;
      logic [15:0] data, busData;
      logic [17:0] busAddr;
      logic rdy;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040; req_wdata = 16'h0;
      @(posedge clk);
      #1;
      junkAddr = 16'($urandom_range(0, 16'h003F));
      req_we = 1'b1; req_addr = junkAddr; req_wdata = 16'($urandom);
      @(negedge clk);
      addrSeen = ram_addr; readSeen = ram_read;
      @(posedge clk);
      #1;
      req_we = 1'b1; req_addr = 16'hBF00; req_wdata = 16'($urandom);
      @(negedge clk);
      respSeen = resp_valid; dataSeen = resp_data;
      req_valid = 1'b0;
      totalChecks++; if (addrSeen !== 18'h00040 || readSeen !== 1'b0) begin badChecks++; $display("[TB] FAIL busy_first_req got=%h/%b exp=00040/0", addrSeen, readSeen); end
      totalChecks++; if (respSeen !== 1'b1 || dataSeen !== refRead(16'h0040)) begin badChecks++; $display("[TB] FAIL busy_resp got=%b/%h exp=1/%h", respSeen, dataSeen, refRead(16'h0040)); end
      @(negedge clk);
      @(negedge clk);
      totalChecks++; if (req_ready !== 1'b1 || uart_wrn !== 1'b1 || ram_en_n !== 1'b1) begin badChecks++; $display("[TB] FAIL busy_ignored ready=%b wrn=%b en_n=%b exp=1/1/1", req_ready, uart_wrn, ram_en_n); end
      applyStimulus(1'b0, junkAddr, 16'h0000, lat, data, enLow, rdnLow, wrnLow, readHigh, readyLow, busData, busAddr, rdy);
      totalChecks++; if (data !== refRead(junkAddr)) begin badChecks++; $display("[TB] FAIL busy_no_write got=%h exp=%h", data, refRead(junkAddr)); end
   endtask

   task automatic test_reset_mid_access();
      logic sawResp;
      int lat, enLow, rdnLow, wrnLow, readHigh, readyLow;
      logic [15:0] data, busData;
      logic [17:0] busAddr;
      logic rdy;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'hBF00; req_wdata = 16'h0055;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      totalChecks++; if (uart_wrn !== 1'b0) begin badChecks++; $display("[TB] FAIL rst_mid_in_wr1 got=%b exp=0", uart_wrn); end
      #2 rst = 1'b1;
      #1;
      totalChecks++; if (uart_wrn !== 1'b1 || req_ready !== 1'b1 || ram_read !== 1'b0) begin badChecks++; $display("[TB] FAIL rst_mid_async wrn=%b ready=%b read=%b exp=1/1/0", uart_wrn, req_ready, ram_read); end
      @(negedge clk);
      rst = 1'b0;
      sawResp = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (resp_valid) sawResp = 1'b1;
      end
      totalChecks++; if (sawResp !== 1'b0 || req_ready !== 1'b1) begin badChecks++; $display("[TB] FAIL rst_mid_dropped resp=%b ready=%b exp=0/1", sawResp, req_ready); end
      applyStimulus(1'b0, 16'h0040, 16'h0000, lat, data, enLow, rdnLow, wrnLow, readHigh, readyLow, busData, busAddr, rdy);
      totalChecks++; if (lat !== 2 || data !== refRead(16'h0040)) begin badChecks++; $display("[TB] FAIL rst_mid_recover lat=%0d data=%h exp=2/%h", lat, data, refRead(16'h0040)); end
   endtask

   task automatic test_random();
      logic [15:0] pool [0:11];
      logic [15:0] addr, wdata, expResp;
      logic we, isData, isStat;
      int expLat, expEn, expRdn, expWrn, expRead;
      int lat, enLow, rdnLow, wrnLow, readHigh, readyLow;
      logic [15:0] data, busData;
      logic [17:0] busAddr;
      logic rdy;
      pool = '{16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0044, 16'hBF02, 16'hBFFF, 16'hBEFF,
               16'hFFFF, 16'hBF00, 16'hBF01, 16'hBF00};
      expResp = resp_data;
      for (int i = 0; i < 60; i++) begin
         addr = pool[$urandom_range(0, 11)];
         we = 1'($urandom);
         wdata = 16'($urandom);
         data_ready = 1'($urandom); tbre = 1'($urandom); tsre = 1'($urandom);
         uartVal = 16'($urandom);
         isData = (addr == 16'hBF00);
         isStat = (addr == 16'hBF01);
         expLat = isStat ? 1 : (isData ? 3 : 2);
         expEn = (isData || isStat) ? 0 : 1;
         expRdn = (isData && !we) ? 2 : 0;
         expWrn = (isData && we) ? 1 : 0;
         expRead = (isData && we) ? 2 : ((!isData && !isStat && we) ? 1 : 0);
         if (!we) expResp = isStat ? {14'b0, data_ready, tbre & tsre}
                          : (isData ? {8'h00, uartVal[7:0]} : refRead(addr));
         else if (!isData && !isStat) refMem[int'(addr)] = wdata;
         applyStimulus(we, addr, wdata, lat, data, enLow, rdnLow, wrnLow, readHigh, readyLow, busData, busAddr, rdy);
         totalChecks++; if (rdy !== 1'b1) begin badChecks++; $display("[TB] FAIL rand_ready_idle i=%0d got=%b exp=1", i, rdy); end
         totalChecks++; if (lat !== expLat || readyLow !== expLat) begin badChecks++; $display("[TB] FAIL rand_latency i=%0d addr=%h lat=%0d ready_low=%0d exp=%0d", i, addr, lat, readyLow, expLat); end
         totalChecks++; if (data !== expResp) begin badChecks++; $display("[TB] FAIL rand_resp_data i=%0d addr=%h we=%b got=%h exp=%h", i, addr, we, data, expResp); end
         totalChecks++; if (enLow !== expEn || rdnLow !== expRdn || wrnLow !== expWrn || readHigh !== expRead) begin
            badChecks++;
            $display("[TB] FAIL rand_strobes i=%0d addr=%h we=%b got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i, addr, we, enLow, rdnLow, wrnLow, readHigh, expEn, expRdn, expWrn, expRead);
         end
         if (we && !isStat) begin
            totalChecks++; if (busData !== wdata || busAddr !== {2'b00, addr}) begin badChecks++; $display("[TB] FAIL rand_store_bus i=%0d got=%h@%h exp=%h@%h", i, busData, busAddr, wdata, {2'b00, addr}); end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 262144; i++) sramMem[i] = 16'h0000;
      sramQ = 16'h0000;
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
      data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0; uartVal = 16'h0;
      test_reset();
      test_sram();
      test_uart_status();
      test_uart_write();
      test_uart_read();
      test_busy();
      test_reset_mid_access();
      test_random();
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
